hram_responder: RTL and testbench

- Synthesizable target-side model of an X8 DDR octal-SPI PSRAM, backed by an internal 32-bit word memory.
- Runs in the same `clk` domain as the HRAM controller and oversamples its `ce`/`ck`/`adq` outputs.
- Decodes command and address and serves read/write bursts over DQS.
- Used in simulation benches and in FPGA loopback builds where no physical PSRAM is fitted.

---
 rtl/hram_pkg.sv | 24 ++
 rtl/hram_mem.sv | 34 +++
 rtl/hram_responder.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_hram_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hram_pkg.sv
// Shared constants and state encoding for the octal-SPI PSRAM responder and its controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hram_pkg;

    // Command opcodes carried in the first command byte
    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h80;

    // Bytes in the command and address phases of every transaction
    localparam int CMD_BYTES  = 2;
    localparam int ADDR_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        LAT,
        RDATA,
        WDATA,
        IGNORE
    } hram_state_t;

endpackage

// File: rtl/hram_mem.sv
// Single-port 32-bit word RAM with per-byte write enables and a registered read port.
// Latency: read data appears one clk after the address is presented; writes land on the same edge.
// Backpressure: none, one access per clk.
module hram_mem #(
    parameter int    AW        = 10,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // The array starts zero-filled.
    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            mem[i] = 32'h0;
        end
    end

    // Byte-lane writes and read-first registered read, shaped for block RAM inference
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/hram_responder.sv
// Target-side X8 DDR octal-SPI PSRAM model oversampling ce/ck/adq from a controller in the same clk domain.
// Latency: two clk from a ck toggle at the pins to the captured byte / updated read byte; LATENCY ck edges before read data.
// Backpressure: none; the controller paces everything with ck and ends a burst by raising ce.
module hram_responder
    import hram_pkg::*;
#(
    parameter int    DEPTH_LOG2 = 10,
    parameter int    LATENCY    = 6,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        ck,
    input  logic [7:0]  adq_in,
    output logic [7:0]  adq_out,
    output logic        adq_oe,
    input  logic        dqs_in,
    output logic        dqs_out,
    output logic        dqs_oe,
    output logic        busy,
    output logic [15:0] wr_count
);

    // Pin sampling stage
    logic        ce_r;
    logic        ck_r;
    logic        ck_d;
    logic [7:0]  adq_r;
    logic        dqs_r;
    logic        ck_edge;

    // Transaction state
    hram_state_t           state, state_nx;
    logic [7:0]            cnt, cnt_nx;
    logic [7:0]            op, op_nx;
    logic                  is_wr, is_wr_nx;
    logic [31:0]           addr, addr_nx;
    logic [DEPTH_LOG2-1:0] index, index_nx;

    // Read path: prefetch pipeline and byte shifter
    logic        pf, pf_nx, pf2;
    logic [31:0] shreg, shreg_nx;

    // Write path: word assembly and commit
    logic [31:0] wword, wword_nx;
    logic [3:0]  wmask, wmask_nx;
    logic        commit, commit_nx;
    logic [1:0]  lane;

    // Registered output next values
    logic [15:0] wr_count_nx;
    logic [7:0]  adq_out_nx;
    logic        adq_oe_nx;
    logic        dqs_out_nx;
    logic        dqs_oe_nx;
    logic        busy_nx;

    // Memory port
    logic [31:0] mem_rdata;
    logic [3:0]  mem_we;

    // The top address byte is only consumed through addr_nx on the last address edge.
    logic addr_unused;
    assign addr_unused = ^addr[31:24];

    assign ck_edge = ck_r ^ ck_d;
    // Byte k of a write word lands in lane 3-k.
    assign lane    = ~cnt[1:0];
    assign mem_we  = commit ? wmask : 4'b0000;

    hram_mem #(
        .AW        (DEPTH_LOG2),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk   (clk),
        .addr  (index),
        .we    (mem_we),
        .wdata (wword),
        .rdata (mem_rdata)
    );

    // One register stage on every bus input; ck is kept twice to detect its edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce_r  <= 1'b1;
            ck_r  <= 1'b0;
            ck_d  <= 1'b0;
            adq_r <= 8'h00;
            dqs_r <= 1'b0;
        end else begin
            ce_r  <= ce;
            ck_r  <= ck;
            ck_d  <= ck_r;
            adq_r <= adq_in;
            dqs_r <= dqs_in;
        end
    end

    // State register and all datapath/output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            op       <= 8'h00;
            is_wr    <= 1'b0;
            addr     <= 32'h0;
            index    <= '0;
            pf       <= 1'b0;
            pf2      <= 1'b0;
            shreg    <= 32'h0;
            wword    <= 32'h0;
            wmask    <= 4'h0;
            commit   <= 1'b0;
            wr_count <= 16'h0;
            adq_out  <= 8'h00;
            adq_oe   <= 1'b0;
            dqs_out  <= 1'b0;
            dqs_oe   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            op       <= op_nx;
            is_wr    <= is_wr_nx;
            addr     <= addr_nx;
            index    <= index_nx;
            pf       <= pf_nx;
            pf2      <= pf;
            shreg    <= shreg_nx;
            wword    <= wword_nx;
            wmask    <= wmask_nx;
            commit   <= commit_nx;
            wr_count <= wr_count_nx;
            adq_out  <= adq_out_nx;
            adq_oe   <= adq_oe_nx;
            dqs_out  <= dqs_out_nx;
            dqs_oe   <= dqs_oe_nx;
            busy     <= busy_nx;
        end
    end

    // Next-state and datapath decode; ce high aborts from any state
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        op_nx       = op;
        is_wr_nx    = is_wr;
        addr_nx     = addr;
        index_nx    = index;
        pf_nx       = 1'b0;
        shreg_nx    = shreg;
        wword_nx    = wword;
        wmask_nx    = wmask;
        commit_nx   = 1'b0;
        wr_count_nx = wr_count;
        adq_out_nx  = adq_out;
        adq_oe_nx   = adq_oe;
        dqs_out_nx  = dqs_out;
        dqs_oe_nx   = dqs_oe;
        busy_nx     = busy;

        // Two clk after the read index settles the RAM output is valid; park it in the shifter.
        if (pf2) begin
            shreg_nx = mem_rdata;
        end

        // A completed write word is committed this cycle (RAM enables come from 'commit'),
        // so the index advances only now and the count saturates.
        if (commit) begin
            index_nx = index + DEPTH_LOG2'(1);
            if (wr_count != 16'hFFFF) begin
                wr_count_nx = wr_count + 16'd1;
            end
        end

        if (ce_r) begin
            state_nx  = IDLE;
            adq_oe_nx = 1'b0;
            dqs_oe_nx = 1'b0;
            busy_nx   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = CMD;
                    busy_nx  = 1'b1;
                    cnt_nx   = 8'd0;
                end

                CMD: begin
                    if (ck_edge) begin
                        if (cnt == 8'd0) begin
                            op_nx = adq_r;
                        end
                        if (cnt == 8'(CMD_BYTES - 1)) begin
                            cnt_nx = 8'd0;
                            if (op == CMD_WRITE) begin
                                state_nx = ADDR;
                                is_wr_nx = 1'b1;
                            end else if (op == CMD_READ) begin
                                state_nx = ADDR;
                                is_wr_nx = 1'b0;
                            end else begin
                                state_nx = IGNORE;
                            end
                        end else begin
                            cnt_nx = cnt + 8'd1;
                        end
                    end
                end

                ADDR: begin
                    if (ck_edge) begin
                        addr_nx = {addr[23:0], adq_r};
                        if (cnt == 8'(ADDR_BYTES - 1)) begin
                            cnt_nx   = 8'd0;
                            index_nx = addr_nx[DEPTH_LOG2+1:2];
                            if (is_wr) begin
                                state_nx = WDATA;
                            end else begin
                                state_nx = LAT;
                                pf_nx    = 1'b1;
                            end
                        end else begin
                            cnt_nx = cnt + 8'd1;
                        end
                    end
                end

                LAT: begin
                    adq_oe_nx = 1'b0;
                    if (ck_edge) begin
                        if (cnt == 8'(LATENCY - 1)) begin
                            cnt_nx     = 8'd0;
                            state_nx   = RDATA;
                            adq_oe_nx  = 1'b1;
                            dqs_oe_nx  = 1'b1;
                            adq_out_nx = shreg[31:24];
                            dqs_out_nx = 1'b1;
                        end else begin
                            cnt_nx = cnt + 8'd1;
                        end
                    end
                end

                RDATA: begin
                    // cnt is the byte currently on the bus; the index moves on while
                    // byte 3 is out so the next word is ready by the following edge.
                    if (ck_edge) begin
                        dqs_out_nx = ~dqs_out;
                        if (cnt == 8'd3) begin
                            cnt_nx     = 8'd0;
                            shreg_nx   = mem_rdata;
                            adq_out_nx = mem_rdata[31:24];
                        end else begin
                            cnt_nx     = cnt + 8'd1;
                            shreg_nx   = {shreg[23:0], 8'h00};
                            adq_out_nx = shreg[23:16];
                            if (cnt == 8'd2) begin
                                index_nx = index + DEPTH_LOG2'(1);
                            end
                        end
                    end
                end

                WDATA: begin
                    // DQS high at the capture edge masks the lane.
                    if (ck_edge) begin
                        wword_nx[8*lane +: 8] = adq_r;
                        wmask_nx[lane]        = ~dqs_r;
                        if (cnt == 8'd3) begin
                            cnt_nx    = 8'd0;
                            commit_nx = 1'b1;
                        end else begin
                            cnt_nx = cnt + 8'd1;
                        end
                    end
                end

                IGNORE: begin
                    adq_oe_nx = 1'b0;
                    dqs_oe_nx = 1'b0;
                end

                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hram_responder.sv
// Directed bench: drives the PSRAM bus like a controller (ck at clk/6) and checks responder outputs.
// Latency: each tick returns two clk after its ck toggle, when the responder has reacted.
// Backpressure: n/a.
module tb_hram_responder;
    import hram_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        ck;
    logic [7:0]  adq_in;
    logic [7:0]  adq_out;
    logic        adq_oe;
    logic        dqs_in;
    logic        dqs_out;
    logic        dqs_oe;
    logic        busy;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hram_responder #(
        .DEPTH_LOG2 (10),
        .LATENCY    (6),
        .INIT_FILE  ("")
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .ck       (ck),
        .adq_in   (adq_in),
        .adq_out  (adq_out),
        .adq_oe   (adq_oe),
        .dqs_in   (dqs_in),
        .dqs_out  (dqs_out),
        .dqs_oe   (dqs_oe),
        .busy     (busy),
        .wr_count (wr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a byte, toggle ck one clk later, return once the responder has seen the edge
    task automatic tick(input logic [7:0] b, input logic d);
        adq_in = b;
        dqs_in = d;
        @(negedge clk);
        ck = ~ck;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic start_cmd();
        ce = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic stop_cmd();
        ce     = 1'b1;
        adq_in = 8'h00;
        dqs_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [31:0] a);
        tick(op, 1'b0);
        tick(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(a[31-8*i -: 8], 1'b0);
        end
    endtask

    // m[3] is the DQS level for byte 0 (lane 31:24)
    task automatic send_word(input logic [31:0] w, input logic [3:0] m);
        for (int k = 0; k < 4; k++) begin
            tick(w[31-8*k -: 8], m[3-k]);
        end
    endtask

    // Read header plus the latency edges; the last edge puts byte 0 on the bus
    task automatic read_lat(input string tag, input logic [31:0] a);
        send_hdr(CMD_READ, a);
        for (int i = 1; i < 6; i++) begin
            tick(8'h00, 1'b0);
            chk({tag, "_lat_oe"}, 32'(adq_oe), 32'd0);
        end
        tick(8'h00, 1'b0);
        chk({tag, "_adq_oe"}, 32'(adq_oe), 32'd1);
        chk({tag, "_dqs_oe"}, 32'(dqs_oe), 32'd1);
    endtask

    task automatic read_word(input string tag, input logic [31:0] w, input bit first);
        for (int k = 0; k < 4; k++) begin
            if (!(first && k == 0)) begin
                tick(8'h00, 1'b0);
            end
            chk({tag, "_byte"}, 32'(adq_out), 32'(w[31-8*k -: 8]));
            chk({tag, "_dqs"}, 32'(dqs_out), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        ce     = 1'b1;
        ck     = 1'b0;
        adq_in = 8'h00;
        dqs_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_adq_out", 32'(adq_out), 32'd0);
        chk("rst_adq_oe", 32'(adq_oe), 32'd0);
        chk("rst_dqs_out", 32'(dqs_out), 32'd0);
        chk("rst_dqs_oe", 32'(dqs_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Full-lane write of 0xDEADBEEF to word 16
        start_cmd();
        chk("wr1_busy", 32'(busy), 32'd1);
        send_hdr(CMD_WRITE, 32'h0000_0040);
        send_word(32'hDEAD_BEEF, 4'b0000);
        chk("wr1_no_drive", 32'(adq_oe), 32'd0);
        stop_cmd();
        chk("wr1_busy_off", 32'(busy), 32'd0);
        chk("wr1_count", 32'(wr_count), 32'd1);

        // Read it back
        start_cmd();
        read_lat("rd1", 32'h0000_0040);
        read_word("rd1", 32'hDEAD_BEEF, 1'b1);
        stop_cmd();
        chk("rd1_adq_oe_off", 32'(adq_oe), 32'd0);
        chk("rd1_dqs_oe_off", 32'(dqs_oe), 32'd0);
        chk("rd1_busy_off", 32'(busy), 32'd0);

        // DQS high on bytes 0 and 2 masks lanes 31:24 and 15:8
        start_cmd();
        send_hdr(CMD_WRITE, 32'h0000_0040);
        send_word(32'h1122_3344, 4'b1010);
        stop_cmd();
        chk("wr2_count", 32'(wr_count), 32'd2);

        // Fully masked word still counts
        start_cmd();
        send_hdr(CMD_WRITE, 32'h0000_0040);
        send_word(32'hFFFF_FFFF, 4'b1111);
        stop_cmd();
        chk("wr3_masked_count", 32'(wr_count), 32'd3);

        // Two bytes then ce high: dropped
        start_cmd();
        send_hdr(CMD_WRITE, 32'h0000_0040);
        tick(8'h99, 1'b0);
        tick(8'h99, 1'b0);
        stop_cmd();
        chk("wr4_partial_count", 32'(wr_count), 32'd3);

        start_cmd();
        read_lat("rd2", 32'h0000_0040);
        read_word("rd2", 32'hDE22_BE44, 1'b1);
        stop_cmd();

        // Two-word write starting at the last word wraps to word 0
        start_cmd();
        send_hdr(CMD_WRITE, 32'h0000_0FFC);
        send_word(32'hA1B2_C3D4, 4'b0000);
        send_word(32'h5566_7788, 4'b0000);
        stop_cmd();
        chk("wr5_count", 32'(wr_count), 32'd5);

        // Read at word 1023 with junk in the upper address bits, streaming across the wrap
        start_cmd();
        read_lat("rd3", 32'hFFFF_0FFC);
        read_word("rd3_w1023", 32'hA1B2_C3D4, 1'b1);
        read_word("rd3_w0", 32'h5566_7788, 1'b0);
        // ce rises together with a ck toggle: abort wins, drivers off
        @(negedge clk);
        ck = ~ck;
        ce = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rd3_abort_adq_oe", 32'(adq_oe), 32'd0);
        chk("rd3_abort_dqs_oe", 32'(dqs_oe), 32'd0);
        chk("rd3_abort_busy", 32'(busy), 32'd0);

        // Unknown opcode: no drive, no write, busy held until ce high
        start_cmd();
        send_hdr(8'h5A, 32'h0000_0040);
        send_word(32'hCAFE_F00D, 4'b0000);
        chk("bad_adq_oe", 32'(adq_oe), 32'd0);
        chk("bad_dqs_oe", 32'(dqs_oe), 32'd0);
        chk("bad_busy", 32'(busy), 32'd1);
        stop_cmd();
        chk("bad_busy_off", 32'(busy), 32'd0);
        chk("bad_count", 32'(wr_count), 32'd5);

        start_cmd();
        read_lat("rd4", 32'h0000_0040);
        read_word("rd4", 32'hDE22_BE44, 1'b1);
        stop_cmd();

        // Asynchronous reset in the middle of a read burst
        start_cmd();
        read_lat("rd5", 32'h0000_0040);
        tick(8'h00, 1'b0);
        chk("rd5_byte1", 32'(adq_out), 32'h22);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_adq_oe", 32'(adq_oe), 32'd0);
        chk("arst_dqs_oe", 32'(dqs_oe), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        ce = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_state", 32'(dut.state), 32'(IDLE));
        chk("arst_rel_busy", 32'(busy), 32'd0);
        chk("arst_wr_count", 32'(wr_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("arst_idle_busy", 32'(busy), 32'd0);

        // Memory survives reset
        start_cmd();
        read_lat("rd6", 32'h0000_0040);
        read_word("rd6", 32'hDE22_BE44, 1'b1);
        stop_cmd();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
